nf_10g_rx_frame_filter: RTL
===========================

// Module: nf_10g_rx_frame_filter
// PURPOSE
//  Receive-side frame admission buffer between the 10G MAC RX stream and the attachment.
//  MAC RX is 64b@clk156 with no backpressure; tuser on the tlast beat flags good (1) or bad (0) frame.
//  Stores frames in a packet FIFO and releases a frame only after its good tlast arrives.
//  Bad frames and frames that overflow are rolled back, never emitted. Output is backpressured AXIS with drop statistics.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   64   data width, in and out (tkeep = /8)
//  C_FIFO_ADDR_WIDTH   9    FIFO depth = 2**C_FIFO_ADDR_WIDTH words (all usable)
//  C_STAT_WIDTH        32   width of each statistics counter
// PORTS
//  clk156              in   1    sole clock
//  areset_clk156       in   1    synchronous reset, active-high
//  s_axis_mac_tdata    in   64   MAC RX data
//  s_axis_mac_tkeep    in   8    byte enables, contiguous from bit 0
//  s_axis_mac_tvalid   in   1    beat valid; no tready, every valid beat must be consumed
//  s_axis_mac_tlast    in   1    last beat of frame
//  s_axis_mac_tuser    in   1    frame good, sampled only with tlast
//  m_axis_tdata        out  64   filtered frame data
//  m_axis_tkeep        out  8    byte enables
//  m_axis_tlast        out  1    last beat
//  m_axis_tvalid       out  1    beat valid
//  m_axis_tready       in   1    downstream ready
//  stat_good_frames    out  32   frames committed
//  stat_bad_frames     out  32   frames dropped, tuser=0
//  stat_ovfl_frames    out  32   frames dropped, FIFO full
//  fifo_words          out  C_FIFO_ADDR_WIDTH+1  occupancy, wr_tmp - rd
// BEHAVIOUR
//  Reset: all pointers 0; state SYNC; m_axis_tvalid/tlast 0; tdata/tkeep 0; counters 0; fifo_words 0.
//  Pointers: wr_tmp, wr_commit and rd are each C_FIFO_ADDR_WIDTH+1 bits and wrap modulo 2**(AW+1).
//  FIFO full: wr_tmp - rd == 2**AW. FIFO data present: rd != wr_commit.
//  RAM word: {tlast, tkeep, tdata}, 73b.
//  FSM, advanced only on input beats except where noted:
//   SYNC: discard beats. Go to IDLE on the first cycle with tvalid=0. Covers reset mid-frame.
//   IDLE/RECV: on a valid beat that is not full, write at wr_tmp and increment wr_tmp. Non-tlast beat -> RECV.
//   tlast beat with tuser=1: wr_commit <= wr_tmp+1; good++; -> IDLE.
//   tlast beat with tuser=0: wr_tmp <= wr_commit; bad++; -> IDLE.
//   Valid beat while full: beat not written; wr_tmp <= wr_commit.
//     If tlast: ovfl++, -> IDLE. Otherwise -> DROP.
//   DROP: discard beats. On tlast: ovfl++ regardless of tuser, -> IDLE.
//  A single-beat frame, tlast on the first beat, follows the same rules.
//  An overflowed bad frame counts as ovfl only. A frame is never partially emitted.
//  Read side: a 1-cycle registered-read RAM feeds a 2-entry output skid.
//   Sustains 1 beat/cycle while m_axis_tready=1 and committed data exist.
//   m_axis_* holds stable while tvalid=1 and tready=0.
//  Latency: tlast written at cycle N. wr_commit is visible at N+1. First beat earliest on m_axis at N+3 with the FIFO and skid empty.
//  Read and write in the same cycle are legal. Occupancy uses pre-edge values of both pointers.
//  The rd pointer never passes wr_commit. Rollback never moves wr_tmp below rd.
//  Counters saturate at all-ones, no wrap.
// STRUCTURE
//  Package nf_10g_rx_pkg:
//   rx_state_t {SYNC, IDLE, RECV, DROP}
//   RX_WORD_W = C_AXIS_DATA_WIDTH + C_AXIS_DATA_WIDTH/8 + 1
//   sat_inc function
//  Sub-module nf_10g_rx_fifo_ram: simple dual-port RAM, one write port, registered read port, 1-cycle latency.
//  Top holds the FSM, pointers, read prefetch/skid and counters.
// TESTING
//  1. Reset, then idle, then good 8-beat frame (tuser=1 on last) with tready=1
//     -> 8 beats out, identical data/tkeep, tlast on beat 8; good=1.
//  2. 8-beat frame with tuser=0 on last -> no m_axis_tvalid; bad=1; fifo_words returns to 0.
//  3. AW=4 (16 words), tready=0, 20-beat good frame -> ovfl=1; fifo_words=0.
//     Next 4-beat good frame is emitted intact after tready=1.
//  4. Back-to-back 1-beat good frames, 1 idle cycle apart, tready toggling 1010
//     -> all emitted in order, no loss or duplicate; m_axis stable while stalled.
//  5. Assert reset mid-frame at beat 3 of 8 -> outputs and counters 0.
//     Remaining beats discarded; next frame after an idle cycle is accepted; good=1.
//  6. Force good counter to 0xFFFFFFFF, send 1 good frame -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/nf_10g_rx_pkg.sv
// Shared types and helpers for the 10G RX frame admission filter.
package nf_10g_rx_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        RECV,
        DROP
    } rx_state_t;

    localparam int RX_DATA_W = 64;
    localparam int RX_WORD_W = RX_DATA_W + RX_DATA_W / 8 + 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nf_10g_rx_fifo_ram.sv
// Simple dual-port packet RAM, one write port and one registered read port.
// Latency: 1 cycle write-to-array, 1 cycle read; no backpressure (caller gates rd_en).
module nf_10g_rx_fifo_ram
    import nf_10g_rx_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = RX_WORD_W
) (
    input  logic          clk156,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk156) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/nf_10g_rx_frame_filter.sv
// RX admission buffer: stores MAC frames, emits only good committed frames, drops bad/overflowed ones.
// Latency: first beat out 3 cycles after good tlast; output backpressured via 2-entry skid, input never stalls.
module nf_10g_rx_frame_filter
    import nf_10g_rx_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_FIFO_ADDR_WIDTH = 9,
    parameter int C_STAT_WIDTH      = 32
) (
    input  logic                           clk156,
    input  logic                           areset_clk156,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_mac_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_mac_tkeep,
    input  logic                           s_axis_mac_tvalid,
    input  logic                           s_axis_mac_tlast,
    input  logic                           s_axis_mac_tuser,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [C_STAT_WIDTH-1:0]        stat_good_frames,
    output logic [C_STAT_WIDTH-1:0]        stat_bad_frames,
    output logic [C_STAT_WIDTH-1:0]        stat_ovfl_frames,
    output logic [C_FIFO_ADDR_WIDTH:0]     fifo_words
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int WW = C_AXIS_DATA_WIDTH + KW + 1;
    localparam int AW = C_FIFO_ADDR_WIDTH;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [C_STAT_WIDTH-1:0] STAT_MAX = '1;

    rx_state_t      state, state_nxt;
    logic [PW-1:0]  wr_tmp, wr_tmp_nxt, wr_commit, wr_commit_nxt, rd;
    logic           full, ram_we, inc_good, inc_bad, inc_ovfl;
    logic           rd_en, rd_pend, pop;
    logic [1:0]     sk_cnt, sk_cnt_pop, sk_cnt_nxt;
    logic [WW-1:0]  sk0, sk1, sk0_nxt, sk1_nxt, ram_rd_dat;

    assign full       = (wr_tmp - rd) == FULL_LVL;
    assign fifo_words = wr_tmp - rd;

    always_comb begin
        state_nxt     = state;
        wr_tmp_nxt    = wr_tmp;
        wr_commit_nxt = wr_commit;
        ram_we        = 1'b0;
        inc_good      = 1'b0;
        inc_bad       = 1'b0;
        inc_ovfl      = 1'b0;
        case (state)
            SYNC: if (!s_axis_mac_tvalid) state_nxt = IDLE;
            IDLE, RECV: begin
                if (s_axis_mac_tvalid) begin
                    if (full) begin
                        // Overflow: discard the partial frame, swallow the rest in DROP.
                        wr_tmp_nxt = wr_commit;
                        if (s_axis_mac_tlast) begin
                            inc_ovfl  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DROP;
                        end
                    end else begin
                        ram_we     = 1'b1;
                        wr_tmp_nxt = wr_tmp + 1'b1;
                        if (!s_axis_mac_tlast) begin
                            state_nxt = RECV;
                        end else if (s_axis_mac_tuser) begin
                            wr_commit_nxt = wr_tmp + 1'b1;
                            inc_good      = 1'b1;
                            state_nxt     = IDLE;
                        end else begin
                            wr_tmp_nxt = wr_commit;
                            inc_bad    = 1'b1;
                            state_nxt  = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (s_axis_mac_tvalid && s_axis_mac_tlast) begin
                    inc_ovfl  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Skid: head drives m_axis; a landing RAM word fills the first free slot after any pop.
    always_comb begin
        pop        = (sk_cnt != 2'd0) && m_axis_tready;
        sk_cnt_pop = sk_cnt - {1'b0, pop};
        sk0_nxt    = pop ? sk1 : sk0;
        sk1_nxt    = sk1;
        if (rd_pend) begin
            if (sk_cnt_pop == 2'd0) sk0_nxt = ram_rd_dat;
            else                    sk1_nxt = ram_rd_dat;
        end
        sk_cnt_nxt = sk_cnt_pop + {1'b0, rd_pend};
        rd_en      = (rd != wr_commit) && (sk_cnt_nxt < 2'd2);
    end

    always_ff @(posedge clk156) begin
        if (areset_clk156) begin
            state            <= SYNC;
            wr_tmp           <= '0;
            wr_commit        <= '0;
            rd               <= '0;
            rd_pend          <= 1'b0;
            sk_cnt           <= 2'd0;
            sk0              <= '0;
            sk1              <= '0;
            stat_good_frames <= '0;
            stat_bad_frames  <= '0;
            stat_ovfl_frames <= '0;
        end else begin
            state     <= state_nxt;
            wr_tmp    <= wr_tmp_nxt;
            wr_commit <= wr_commit_nxt;
            if (rd_en) rd <= rd + 1'b1;
            rd_pend   <= rd_en;
            sk_cnt    <= sk_cnt_nxt;
            sk0       <= sk0_nxt;
            sk1       <= sk1_nxt;
            if (inc_good)
                stat_good_frames <= C_STAT_WIDTH'(sat_inc(32'(stat_good_frames), 32'(STAT_MAX)));
            if (inc_bad)
                stat_bad_frames  <= C_STAT_WIDTH'(sat_inc(32'(stat_bad_frames), 32'(STAT_MAX)));
            if (inc_ovfl)
                stat_ovfl_frames <= C_STAT_WIDTH'(sat_inc(32'(stat_ovfl_frames), 32'(STAT_MAX)));
        end
    end

    assign m_axis_tvalid = (sk_cnt != 2'd0);
    assign m_axis_tlast  = sk0[WW-1];
    assign m_axis_tkeep  = sk0[WW-2 -: KW];
    assign m_axis_tdata  = sk0[C_AXIS_DATA_WIDTH-1:0];

    nf_10g_rx_fifo_ram #(
        .AW (AW),
        .DW (WW)
    ) u_ram (
        .clk156  (clk156),
        .wr_en   (ram_we),
        .wr_addr (wr_tmp[AW-1:0]),
        .wr_dat  ({s_axis_mac_tlast, s_axis_mac_tkeep, s_axis_mac_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd[AW-1:0]),
        .rd_dat  (ram_rd_dat)
    );

endmodule
